// File: rtl/booth_mul_32.sv
// Radix-4 Booth signed 32x32->64 multiplier, one op per clock, no backpressure (valid-only stream).
// Latency 2 cycles; 3 when BOOTH_PIPE_EN registers the sum/carry vectors before the final add.
module booth_mul_32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] z,
  output logic               out_valid
);

  localparam int PW        = 2 * WIDTH;
  localparam int NPP       = WIDTH / 2;
  localparam int NROW      = NPP + 1;
  localparam int MW        = WIDTH + 2;
  // 3:2 levels needed to take 17 rows down to 2: 17-12-8-6-4-3-2
  localparam int TREE_LVLS = 6;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  logic [WIDTH:0]  b_ext;
  logic [NPP-1:0]  dig_neg;
  logic [NPP-1:0]  dig_one;
  logic [NPP-1:0]  dig_two;

  assign b_ext = {b_q, 1'b0};

  always_comb begin
    dig_neg = '0;
    dig_one = '0;
    dig_two = '0;
    for (int i = 0; i < NPP; i++) begin
      dig_one[i] = b_ext[2*i+1] ^ b_ext[2*i];
      dig_two[i] = ( b_ext[2*i+2] & ~b_ext[2*i+1] & ~b_ext[2*i]) |
                   (~b_ext[2*i+2] &  b_ext[2*i+1] &  b_ext[2*i]);
      dig_neg[i] = b_ext[2*i+2] & ~(b_ext[2*i+1] & b_ext[2*i]);
    end
  end

  logic [MW-1:0] a_ext;
  logic [MW-1:0] mag [NPP];
  logic [PW-1:0] pp  [NROW];

  assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};

  // Negative digits use the one's complement here; the +1 lands in the extra row pp[NPP]
  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      mag[i] = (({MW{dig_one[i]}} & a_ext) |
                ({MW{dig_two[i]}} & {a_ext[MW-2:0], 1'b0})) ^ {MW{dig_neg[i]}};
      pp[i]  = {{(PW-MW){mag[i][MW-1]}}, mag[i]} << (2 * i);
    end
    pp[NPP] = '0;
    for (int i = 0; i < NPP; i++) begin
      pp[NPP][2*i] = dig_neg[i];
    end
  end

  logic [PW-1:0] row [NROW];
  logic [PW-1:0] csa_x;
  logic [PW-1:0] csa_y;
  logic [PW-1:0] csa_w;
  int            n_rows;
  int            n_next;
  logic [PW-1:0] red_s;
  logic [PW-1:0] red_c;

  // Wallace-style reduction done in place: each level folds groups of three rows into
  // sum/carry pairs and slides the leftover rows down behind them.
  always_comb begin
    for (int k = 0; k < NROW; k++) begin
      row[k] = pp[k];
    end
    csa_x  = '0;
    csa_y  = '0;
    csa_w  = '0;
    n_rows = NROW;
    n_next = 0;
    for (int lvl = 0; lvl < TREE_LVLS; lvl++) begin
      n_next = 0;
      for (int k = 0; k + 2 < NROW; k += 3) begin
        if (k + 2 < n_rows) begin
          csa_x          = row[k];
          csa_y          = row[k+1];
          csa_w          = row[k+2];
          row[n_next]    = csa_x ^ csa_y ^ csa_w;
          row[n_next+1]  = ((csa_x & csa_y) | (csa_x & csa_w) | (csa_y & csa_w)) << 1;
          n_next         = n_next + 2;
        end
      end
      for (int k = 0; k < NROW; k++) begin
        if (k >= 3 * (n_rows / 3) && k < n_rows) begin
          row[n_next] = row[k];
          n_next      = n_next + 1;
        end
      end
      n_rows = n_next;
    end
    red_s = row[0];
    red_c = row[1];
  end

  logic [PW-1:0] fin_s;
  logic [PW-1:0] fin_c;
  logic          fin_vld;

`ifdef BOOTH_PIPE_EN
  logic [PW-1:0] sum_q;
  logic [PW-1:0] cry_q;
  logic          vld2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cry_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      vld2_q <= vld_q;
      if (vld_q) begin
        sum_q <= red_s;
        cry_q <= red_c;
      end
    end
  end

  assign fin_s   = sum_q;
  assign fin_c   = cry_q;
  assign fin_vld = vld2_q;
`else
  assign fin_s   = red_s;
  assign fin_c   = red_c;
  assign fin_vld = vld_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        z <= fin_s + fin_c;
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_32.sv
// Scoreboard bench for booth_mul_32: expected products queued at drive time, popped on out_valid.
`timescale 1ns/1ps
module tb_booth_mul_32;

`ifdef BOOTH_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] z;
  logic        out_valid;

  booth_mul_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .z         (z),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          rst_at_edge = 1'b0;
  logic [63:0] exp_q [$];
  int          cyc_q [$];
  logic [63:0] last_z = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = !rst_n;
    if (!rst_n) armed = 1'b1;
  end

  always @(negedge clk) begin
    logic [63:0] ez;
    int          ec;
    if (armed) begin
      if (rst_at_edge) begin
        chk("rst_z", z, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        last_z = '0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {63'h0, out_valid}, 64'h0);
        end else begin
          ez = exp_q.pop_front();
          ec = cyc_q.pop_front();
          chk("product", z, ez);
          chk("latency_cycle", 64'(cyc), 64'(ec));
          last_z = ez;
        end
      end else begin
        chk("hold_z", z, last_z);
        if (cyc_q.size() != 0 && cyc_q[0] <= cyc) begin
          chk("missing_out_valid", {63'h0, out_valid}, 64'h1);
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end
    end
  end

  // Capture edge is cyc+1; product shows up after edge cyc+LAT.
  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y);
    longint p;
    in_valid = v;
    if (v) begin
      a = x;
      b = y;
    end else begin
      a = 'x;
      b = 'x;
    end
    if (v && rst_n) begin
      p = longint'(signed'(x)) * longint'(signed'(y));
      exp_q.push_back(p);
      cyc_q.push_back(cyc + LAT);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 32'd5;
    b        = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(1'b1, 32'd15, 32'd10);
    repeat (LAT + 1) drive(1'b0, '0, '0);

    drive(1'b1, 32'd12, 32'(-5));
    drive(1'b1, 32'(-7), 32'd6);
    drive(1'b1, 32'(-9), 32'(-11));

    drive(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    drive(1'b1, 32'h8000_0000, 32'h8000_0000);
    drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(1'b1, 32'h0000_0000, 32'h8000_0000);
    drive(1'b1, 32'h8000_0000, 32'h0000_0000);
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0001);
    repeat (LAT + 1) drive(1'b0, '0, '0);

    drive(1'b1, 32'd1234, 32'(-4321));
    drive(1'b0, '0, '0);
    drive(1'b1, 32'(-100000), 32'd99999);
    repeat (LAT + 2) drive(1'b0, '0, '0);

    drive(1'b1, 32'd77, 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    drive(1'b0, '0, '0);
    rst_n = 1'b1;
    repeat (LAT + 2) drive(1'b0, '0, '0);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) drive(1'b0, '0, '0);
      else drive(1'b1, pick(), pick());
    end

    repeat (LAT + 2) drive(1'b0, '0, '0);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
